// File: rtl/kws_pkg.sv
// ---------------------------------------------------------------------------
// kws_pkg
// Shared definitions for the keyword-spotting decision path: the decision FSM
// state type, default geometry of the score vectors and moving-average window,
// and a helper that sizes class-index fields.
// Used by kws_score_history, kws_decision and the softmax/host-side blocks.
// ---------------------------------------------------------------------------
package kws_pkg;

    // Decision FSM: wait for a frame, fold it in one class per cycle, then decide.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } kws_state_t;

    localparam int KWS_NUM_KEYWORDS    = 10;
    localparam int KWS_SCORE_BITS      = 8;
    localparam int KWS_WIN_LOG2        = 3;
    localparam int KWS_SUM_BITS        = KWS_SCORE_BITS + KWS_WIN_LOG2;
    localparam int KWS_REFRACT_FRAMES  = 16;
    localparam int KWS_BG_CLASS        = 0;
    localparam int KWS_DEBOUNCE_FRAMES = 3;

    // Width of a class-index field; never narrower than one bit.
    function automatic int kws_idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kws_score_history.sv
// ---------------------------------------------------------------------------
// kws_score_history
// Per-class moving-average storage: a NUM_KEYWORDS x 2**WIN_LOG2 history of
// raw scores, the shared write pointer, a saturating fill counter and one
// running sum per class.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous clear of all history, sums, pointer and fill
//   upd_en       fold upd_val into class upd_idx at the current pointer slot
//   upd_idx      class being updated
//   upd_val      new raw score for that class
//   advance      end of frame: move the pointer, bump the fill counter
//   upd_avg      averaged score of upd_idx including upd_val (combinational)
//   full_incl    window is full once the frame being decided is counted
// ---------------------------------------------------------------------------
module kws_score_history
    import kws_pkg::*;
#(
    parameter int NUM_KEYWORDS = KWS_NUM_KEYWORDS,
    parameter int SCORE_BITS   = KWS_SCORE_BITS,
    parameter int WIN_LOG2     = KWS_WIN_LOG2,
    parameter int IDX_W        = kws_idx_bits(KWS_NUM_KEYWORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  upd_en,
    input  logic [IDX_W-1:0]      upd_idx,
    input  logic [SCORE_BITS-1:0] upd_val,
    input  logic                  advance,
    output logic [SCORE_BITS-1:0] upd_avg,
    output logic                  full_incl
);

    localparam int WIN    = 1 << WIN_LOG2;
    localparam int SUM_W  = SCORE_BITS + WIN_LOG2;
    localparam int FILL_W = WIN_LOG2 + 1;

    logic [SUM_W-1:0]      sums [NUM_KEYWORDS];
    logic [SCORE_BITS-1:0] hist [NUM_KEYWORDS][WIN];
    logic [WIN_LOG2-1:0]   wptr;
    logic [FILL_W-1:0]     fill;
    logic [SUM_W-1:0]      next_sum;

    // The slot being overwritten is always part of the current sum, so the
    // subtraction cannot underflow and the sum never exceeds WIN*max score.
    assign next_sum  = sums[upd_idx] - SUM_W'(hist[upd_idx][wptr]) + SUM_W'(upd_val);
    assign upd_avg   = next_sum[SUM_W-1:WIN_LOG2];

    // The fill counter only advances at the end of a frame, so the frame
    // currently being decided is the one that takes it from WIN-1 to WIN.
    assign full_incl = (fill >= FILL_W'(WIN - 1));

    // History, sums, pointer and fill; a clear behaves like a fresh reset so
    // the warm-up window starts over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYWORDS; k++) begin
                sums[k] <= '0;
                for (int w = 0; w < WIN; w++) hist[k][w] <= '0;
            end
            wptr <= '0;
            fill <= '0;
        end else if (clear) begin
            for (int k = 0; k < NUM_KEYWORDS; k++) begin
                sums[k] <= '0;
                for (int w = 0; w < WIN; w++) hist[k][w] <= '0;
            end
            wptr <= '0;
            fill <= '0;
        end else begin
            if (upd_en) begin
                sums[upd_idx]       <= next_sum;
                hist[upd_idx][wptr] <= upd_val;
            end
            if (advance) begin
                wptr <= wptr + 1'b1;
                if (fill != FILL_W'(WIN)) fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kws_decision.sv
// ---------------------------------------------------------------------------
// kws_decision
// Keyword decision stage after the CNN-KWS softmax. Each accepted score frame
// is folded into per-class moving averages one class per cycle, the winning
// class is found, and a one-cycle detection is emitted when the winner is not
// background, clears the threshold, the window is warm and the refractory
// hold-off has expired.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   score_in      packed class scores, class k at [k*SCORE_BITS +: SCORE_BITS]
//   score_valid   frame offered this cycle
//   score_ready   frame can be accepted this cycle (IDLE and no flush)
//   threshold     minimum averaged score, captured with the frame
//   flush         synchronous clear of all history and decision state
//   detect_valid  one-cycle detection strobe
//   detect_idx    detected class, held until the next detection
//   detect_score  averaged score of the detected class, held likewise
//   overrun       sticky flag: a frame was offered while not ready
// Build option: define KWS_DEBOUNCE_EN to require KWS_DEBOUNCE_FRAMES
// consecutive frames agreeing on the same candidate before detecting.
// ---------------------------------------------------------------------------
module kws_decision
    import kws_pkg::*;
#(
    parameter int NUM_KEYWORDS   = KWS_NUM_KEYWORDS,
    parameter int SCORE_BITS     = KWS_SCORE_BITS,
    parameter int WIN_LOG2       = KWS_WIN_LOG2,
    parameter int REFRACT_FRAMES = KWS_REFRACT_FRAMES,
    parameter int BG_CLASS       = KWS_BG_CLASS,
    parameter int IDX_W          = kws_idx_bits(KWS_NUM_KEYWORDS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_KEYWORDS*SCORE_BITS-1:0] score_in,
    input  logic                               score_valid,
    output logic                               score_ready,
    input  logic [SCORE_BITS-1:0]              threshold,
    input  logic                               flush,
    output logic                               detect_valid,
    output logic [IDX_W-1:0]                   detect_idx,
    output logic [SCORE_BITS-1:0]              detect_score,
    output logic                               overrun
);

    localparam int REF_W = $clog2(REFRACT_FRAMES + 1);

    kws_state_t                          state, state_next;
    logic [IDX_W-1:0]                    k_cnt;
    logic [NUM_KEYWORDS*SCORE_BITS-1:0]  frame_q;
    logic [SCORE_BITS-1:0]               thr_q;
    logic [IDX_W-1:0]                    best_idx;
    logic [SCORE_BITS-1:0]               best_avg;
    logic [REF_W-1:0]                    refract_cnt;
    logic                                accept;
    logic                                hist_upd;
    logic                                hist_adv;
    logic [SCORE_BITS-1:0]               upd_avg;
    logic                                full_incl;
    logic                                candidate;
    logic                                debounce_ok;
    logic                                do_detect;

    kws_score_history #(
        .NUM_KEYWORDS (NUM_KEYWORDS),
        .SCORE_BITS   (SCORE_BITS),
        .WIN_LOG2     (WIN_LOG2),
        .IDX_W        (IDX_W)
    ) u_history (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .upd_en    (hist_upd),
        .upd_idx   (k_cnt),
        .upd_val   (frame_q[int'(k_cnt)*SCORE_BITS +: SCORE_BITS]),
        .advance   (hist_adv),
        .upd_avg   (upd_avg),
        .full_incl (full_incl)
    );

    assign accept = score_valid && score_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and per-state strobes; a flush anywhere abandons the frame.
    always_comb begin
        state_next  = state;
        score_ready = 1'b0;
        hist_upd    = 1'b0;
        hist_adv    = 1'b0;
        case (state)
            IDLE: begin
                score_ready = !flush;
                if (accept) state_next = ACCUM;
            end
            ACCUM: begin
                hist_upd = 1'b1;
                if (k_cnt == IDX_W'(NUM_KEYWORDS - 1)) state_next = DECIDE;
            end
            DECIDE: begin
                hist_adv   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Frame capture and class sweep counter; the counter rests at 0 outside
    // ACCUM so each frame starts with class 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            thr_q   <= '0;
            k_cnt   <= '0;
        end else begin
            if (accept) begin
                frame_q <= score_in;
                thr_q   <= threshold;
            end
            if (state == ACCUM && !flush) k_cnt <= k_cnt + 1'b1;
            else                          k_cnt <= '0;
        end
    end

    // Running argmax over the freshly updated averages; strict '>' keeps the
    // lowest index on a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_idx <= '0;
            best_avg <= '0;
        end else if (flush) begin
            best_idx <= '0;
            best_avg <= '0;
        end else if (state == ACCUM) begin
            if (k_cnt == '0 || upd_avg > best_avg) begin
                best_idx <= k_cnt;
                best_avg <= upd_avg;
            end
        end
    end

    assign candidate = full_incl && (best_idx != IDX_W'(BG_CLASS)) && (best_avg >= thr_q);

`ifdef KWS_DEBOUNCE_EN
    localparam int DB_W = $clog2(KWS_DEBOUNCE_FRAMES + 1);

    logic [DB_W-1:0]  db_cnt, db_next;
    logic [IDX_W-1:0] db_idx;

    // Count consecutive frames nominating the same candidate, saturating at
    // the required run length; this frame's vote is included.
    always_comb begin
        db_next = '0;
        if (candidate) begin
            if (db_cnt != '0 && db_idx == best_idx)
                db_next = (db_cnt >= DB_W'(KWS_DEBOUNCE_FRAMES)) ? db_cnt : db_cnt + 1'b1;
            else
                db_next = DB_W'(1);
        end
    end

    assign debounce_ok = (db_next >= DB_W'(KWS_DEBOUNCE_FRAMES));

    // Debounce history, updated once per decided frame and reset by a detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt <= '0;
            db_idx <= '0;
        end else if (flush) begin
            db_cnt <= '0;
            db_idx <= '0;
        end else if (state == DECIDE) begin
            if (candidate) db_idx <= best_idx;
            db_cnt <= do_detect ? '0 : db_next;
        end
    end
`else
    assign debounce_ok = 1'b1;
`endif

    assign do_detect = (state == DECIDE) && !flush && candidate &&
                       (refract_cnt == '0) && debounce_ok;

    // Registered detection outputs and refractory hold-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            detect_valid <= 1'b0;
            detect_idx   <= '0;
            detect_score <= '0;
            refract_cnt  <= '0;
        end else if (flush) begin
            detect_valid <= 1'b0;
            detect_idx   <= '0;
            detect_score <= '0;
            refract_cnt  <= '0;
        end else begin
            detect_valid <= do_detect;
            if (do_detect) begin
                detect_idx   <= best_idx;
                detect_score <= best_avg;
                refract_cnt  <= REF_W'(REFRACT_FRAMES);
            end else if (state == DECIDE && refract_cnt != '0) begin
                refract_cnt <= refract_cnt - 1'b1;
            end
        end
    end

    // Sticky overrun flag; flush wins over a simultaneous offer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              overrun <= 1'b0;
        else if (flush)                       overrun <= 1'b0;
        else if (score_valid && !score_ready) overrun <= 1'b1;
    end

endmodule

// File: tb/tb_kws_decision.sv
// ---------------------------------------------------------------------------
// tb_kws_decision
// Scoreboard bench for kws_decision: stimulus pushes the expected detections
// (class, averaged score, cycle) into a queue, and a monitor pops and compares
// every detect_valid pulse the DUT produces.
// ---------------------------------------------------------------------------
module tb_kws_decision;
    import kws_pkg::*;

    localparam int NK = KWS_NUM_KEYWORDS;
    localparam int SB = KWS_SCORE_BITS;
    localparam int FW = NK * SB;
    localparam int IW = kws_idx_bits(KWS_NUM_KEYWORDS);
    localparam int LAT = NK + 2;
`ifdef KWS_DEBOUNCE_EN
    localparam int DB_EXTRA = 2;
`else
    localparam int DB_EXTRA = 0;
`endif

    typedef struct {
        int idx;
        int score;
        int cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] score_in = '0;
    logic          score_valid = 1'b0;
    logic          score_ready;
    logic [SB-1:0] threshold = 8'd128;
    logic          flush = 1'b0;
    logic          detect_valid;
    logic [IW-1:0] detect_idx;
    logic [SB-1:0] detect_score;
    logic          overrun;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    kws_decision dut (
        .clk          (clk),
        .rst          (rst),
        .score_in     (score_in),
        .score_valid  (score_valid),
        .score_ready  (score_ready),
        .threshold    (threshold),
        .flush        (flush),
        .detect_valid (detect_valid),
        .detect_idx   (detect_idx),
        .detect_score (detect_score),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [FW-1:0] mkFrame(input int c1, input int v1, input int c2, input int v2);
        logic [FW-1:0] f;
        f = '0;
        if (c1 >= 0) f[c1*SB +: SB] = SB'(v1);
        if (c2 >= 0) f[c2*SB +: SB] = SB'(v2);
        return f;
    endfunction

    // Offer one frame and, if it should trigger a detection, register the
    // expected class/score/cycle with the scoreboard.
    task automatic applyStimulus(input logic [FW-1:0] f, input logic exp_det,
                                 input int idx, input int sc);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!score_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!score_ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        score_in    = f;
        score_valid = 1'b1;
        if (exp_det) sb_q.push_back('{idx, sc, cyc + LAT});
        @(posedge clk);
        #1 score_valid = 1'b0;
    endtask

    task automatic flushPulse();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (LAT + 4) @(negedge clk);
        checkOutput(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Monitor: every detection must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && detect_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_detect", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("det_idx", int'(detect_idx), e.idx);
                checkOutput("det_score", int'(detect_score), e.score);
                checkOutput("det_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [FW-1:0] f3;
        f3 = mkFrame(3, 255, -1, 0);

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_detect_valid", int'(detect_valid), 0);
        checkOutput("rst_detect_idx", int'(detect_idx), 0);
        checkOutput("rst_detect_score", int'(detect_score), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        checkOutput("rst_ready", int'(score_ready), 1);
        rst = 1'b0;

        // Reset in the middle of ACCUM discards the partial frame
        applyStimulus(f3, 1'b0, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("midrst_ready", int'(score_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        drain("midrst_drain");

        // Warm-up and refractory: detections only on frames 8 and 25
        $display("[TB] warm-up / refractory");
        for (int n = 1; n <= 26 + DB_EXTRA; n++)
            applyStimulus(f3, (n == 8 + DB_EXTRA) || (n == 25 + DB_EXTRA), 3, 255);
        drain("refract_drain");

        // Threshold boundary
        $display("[TB] threshold");
        flushPulse();
        for (int n = 1; n <= 10; n++)
            applyStimulus(mkFrame(5, 127, -1, 0), 1'b0, 0, 0);
        drain("thr127_drain");
        flushPulse();
        for (int n = 1; n <= 8 + DB_EXTRA; n++)
            applyStimulus(mkFrame(5, 128, -1, 0), n == 8 + DB_EXTRA, 5, 128);
        drain("thr128_drain");

        // Tie resolves to the lower index; outputs hold afterwards
        $display("[TB] tie / background");
        flushPulse();
        for (int n = 1; n <= 8 + DB_EXTRA; n++)
            applyStimulus(mkFrame(2, 200, 7, 200), n == 8 + DB_EXTRA, 2, 200);
        drain("tie_drain");
        checkOutput("hold_idx", int'(detect_idx), 2);
        checkOutput("hold_score", int'(detect_score), 200);

        // Background winner is never reported
        flushPulse();
        for (int n = 1; n <= 10; n++)
            applyStimulus(mkFrame(0, 255, 4, 200), 1'b0, 0, 0);
        drain("bg_drain");

        // Overrun: valid held while busy sets the sticky flag
        $display("[TB] overrun / flush");
        flushPulse();
        checkOutput("overrun_clear0", int'(overrun), 0);
        applyStimulus(f3, 1'b0, 0, 0);
        @(negedge clk);
        score_in    = mkFrame(5, 255, -1, 0);
        score_valid = 1'b1;
        repeat (3) @(negedge clk);
        score_valid = 1'b0;
        checkOutput("overrun_set", int'(overrun), 1);
        drain("overrun_drain");
        checkOutput("overrun_sticky", int'(overrun), 1);
        flushPulse();
        checkOutput("overrun_flushed", int'(overrun), 0);

        // Flush mid-frame aborts it and restarts the warm-up
        for (int n = 1; n <= 7; n++)
            applyStimulus(f3, 1'b0, 0, 0);
        applyStimulus(f3, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        flushPulse();
        drain("abort_drain");
        for (int n = 1; n <= 8 + DB_EXTRA; n++)
            applyStimulus(f3, n == 8 + DB_EXTRA, 3, 255);
        drain("rewarm_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
